// File: rtl/dec4_7seg_scan.sv
// Four-digit multiplexed 7-segment display driver.
// The BCD word is captured on a load strobe and shown one digit at a time
// on a shared segment bus. Leading zeros can be blanked. Nibbles 10..15 show
// a minus sign. A one-cycle frame pulse marks each completed scan.
module dec4_7seg_scan #(
  parameter int unsigned DIV = 50000,  // clock cycles per digit slot, 2..2^20
  parameter bit          LZB = 1'b1    // 1 = blank leading zeros
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] DEC,
  input  logic        ld,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame
);

  localparam int unsigned     CW      = $clog2(DIV);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_ptr;
  logic [15:0]   r_disp;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;
  logic          r_wrap;
  logic          r_frame;

  logic          w_tick;
  logic [3:0]    w_nib;
  logic [3:0]    w_blank_vec;
  logic          w_blank;
  logic [6:0]    w_enc;

  assign w_tick = (r_cnt == CNT_MAX);
  assign w_nib  = r_disp[4*r_ptr +: 4];

  // Digit k (k >= 1) is a leading zero when it and every digit above it are
  // zero. An invalid nibble is non-zero, so it keeps lower digits visible.
  // Digit 0 is never blanked so a value of zero still shows one "0".
  assign w_blank_vec[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_blank
      assign w_blank_vec[gi] = LZB && (r_disp[15:4*gi] == '0);
    end
  endgenerate
  assign w_blank = w_blank_vec[r_ptr];

  // Segment encoder: {g,f,e,d,c,b,a}, active-high; invalid BCD shows '-'.
  always_comb begin
    w_enc = 7'h40;
    case (w_nib)
      4'd0: w_enc = 7'h3F;
      4'd1: w_enc = 7'h06;
      4'd2: w_enc = 7'h5B;
      4'd3: w_enc = 7'h4F;
      4'd4: w_enc = 7'h66;
      4'd5: w_enc = 7'h6D;
      4'd6: w_enc = 7'h7D;
      4'd7: w_enc = 7'h07;
      4'd8: w_enc = 7'h7F;
      4'd9: w_enc = 7'h6F;
      default: w_enc = 7'h40;
    endcase
  end

  // Prescaler and digit pointer: the pointer advances once per DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_ptr <= 2'd0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_ptr <= r_ptr + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Shadow register: the display only changes on an explicit load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp <= 16'h0000;
    end else if (ld) begin
      r_disp <= DEC;
    end
  end

  // Output register. The wrap flag is delayed one stage so that frame is
  // high in the same cycle the anodes first select digit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an    <= 4'b1111;
      r_seg   <= 7'h00;
      r_wrap  <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_an    <= w_blank ? 4'b1111 : ~(4'b0001 << r_ptr);
      r_seg   <= w_blank ? 7'h00 : w_enc;
      r_wrap  <= w_tick && (r_ptr == 2'd3);
      r_frame <= r_wrap;
    end
  end

  assign seg   = r_seg;
  assign an    = r_an;
  assign frame = r_frame;

endmodule

// File: tb/tb_dec4_7seg_scan.sv
// Directed testbench for dec4_7seg_scan with DIV = 4.
// Two instances share all inputs: one with leading-zero blanking, one without.
module tb_dec4_7seg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] DEC;
  logic        ld;
  logic [6:0]  seg1, seg0;
  logic [3:0]  an1, an0;
  logic        frame1, frame0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dec4_7seg_scan #(.DIV(4), .LZB(1'b1)) dut_lzb (
    .clk(clk), .rst(rst), .DEC(DEC), .ld(ld),
    .seg(seg1), .an(an1), .frame(frame1)
  );

  dec4_7seg_scan #(.DIV(4), .LZB(1'b0)) dut_all (
    .clk(clk), .rst(rst), .DEC(DEC), .ld(ld),
    .seg(seg0), .an(an0), .frame(frame0)
  );

  // Advance one clock; outputs are sampled and inputs driven 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until the blanking instance pulses frame (bounded).
  task automatic wait_frame();
    bit found;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      step();
      if (frame1 === 1'b1) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL wait_frame: frame=%b within 40 cycles, required 1", frame1);
    end
  endtask

  task automatic load(input logic [15:0] value);
    DEC = value;
    ld  = 1'b1;
    step();
    ld  = 1'b0;
    $display("load DEC=%h", value);
  endtask

  task automatic test_reset();
    rst = 1'b1; ld = 1'b1; DEC = 16'h8888;
    step();
    step();
    total++;
    if (an1 !== 4'b1111 || seg1 !== 7'h00 || frame1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_lzb: an=%b seg=%h frame=%b, required an=1111 seg=00 frame=0", an1, seg1, frame1);
    end
    total++;
    if (an0 !== 4'b1111 || seg0 !== 7'h00 || frame0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_all: an=%b seg=%h frame=%b, required an=1111 seg=00 frame=0", an0, seg0, frame0);
    end
    rst = 1'b0; ld = 1'b0;
    // Digit 0 is shown for exactly 4 cycles after release; ld during rst was ignored.
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (an1 !== 4'b1110 || seg1 !== 7'h3F || frame1 !== 1'b0) begin
        bad++;
        $display("FAIL release_d0 i=%0d: an=%b seg=%h frame=%b, required an=1110 seg=3F frame=0", i, an1, seg1, frame1);
      end
    end
    step();
    total++;
    if (an1 !== 4'b1111 || seg1 !== 7'h00) begin
      bad++;
      $display("FAIL release_d1_lzb: an=%b seg=%h, required an=1111 seg=00", an1, seg1);
    end
    total++;
    if (an0 !== 4'b1101 || seg0 !== 7'h3F) begin
      bad++;
      $display("FAIL release_d1_all: an=%b seg=%h, required an=1101 seg=3F", an0, seg0);
    end
    $display("test_reset complete");
  endtask

  task automatic test_full_scan();
    logic [6:0] es[4];
    logic [3:0] ea[4];
    int k;
    es = '{7'h66, 7'h4F, 7'h5B, 7'h06};
    ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    load(16'h1234);
    wait_frame();
    for (int i = 0; i < 17; i++) begin
      if (i > 0) step();
      k = (i / 4) % 4;
      total++;
      if (an1 !== ea[k] || seg1 !== es[k]) begin
        bad++;
        $display("FAIL scan i=%0d: an=%b seg=%h, required an=%b seg=%h", i, an1, seg1, ea[k], es[k]);
      end
      total++;
      if (frame1 !== 1'((i % 16) == 0)) begin
        bad++;
        $display("FAIL scan_frame i=%0d: frame=%b, required %b", i, frame1, 1'((i % 16) == 0));
      end
    end
    $display("test_full_scan complete");
  endtask

  task automatic test_blanking();
    logic [6:0] es1[4], es0[4];
    logic [3:0] ea1[4], ea0[4];
    int k;
    es1 = '{7'h3F, 7'h07, 7'h00, 7'h00};
    ea1 = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    es0 = '{7'h3F, 7'h07, 7'h3F, 7'h3F};
    ea0 = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    load(16'h0070);
    wait_frame();
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      k = i / 4;
      total++;
      if (an1 !== ea1[k] || seg1 !== es1[k]) begin
        bad++;
        $display("FAIL blank_lzb i=%0d: an=%b seg=%h, required an=%b seg=%h", i, an1, seg1, ea1[k], es1[k]);
      end
      total++;
      if (an0 !== ea0[k] || seg0 !== es0[k]) begin
        bad++;
        $display("FAIL blank_all i=%0d: an=%b seg=%h, required an=%b seg=%h", i, an0, seg0, ea0[k], es0[k]);
      end
    end
    $display("test_blanking complete");
  endtask

  task automatic test_invalid();
    logic [6:0] es1[4], es0[4];
    logic [3:0] ea1[4], ea0[4];
    int k;
    es1 = '{7'h6D, 7'h3F, 7'h40, 7'h00};
    ea1 = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
    es0 = '{7'h6D, 7'h3F, 7'h40, 7'h3F};
    ea0 = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    load(16'h0A05);
    wait_frame();
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      k = i / 4;
      total++;
      if (an1 !== ea1[k] || seg1 !== es1[k]) begin
        bad++;
        $display("FAIL invalid_lzb i=%0d: an=%b seg=%h, required an=%b seg=%h", i, an1, seg1, ea1[k], es1[k]);
      end
      total++;
      if (an0 !== ea0[k] || seg0 !== es0[k]) begin
        bad++;
        $display("FAIL invalid_all i=%0d: an=%b seg=%h, required an=%b seg=%h", i, an0, seg0, ea0[k], es0[k]);
      end
    end
    $display("test_invalid complete");
  endtask

  task automatic test_hold_reload();
    logic [3:0] ea[4];
    ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    load(16'h9999);
    DEC = 16'h0001;  // no ld: display must not follow
    wait_frame();
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      total++;
      if (an1 !== ea[i/4] || seg1 !== 7'h6F) begin
        bad++;
        $display("FAIL hold i=%0d: an=%b seg=%h, required an=%b seg=6F", i, an1, seg1, ea[i/4]);
      end
    end
    // Frame edge E sampled; the next tick is at edge E+3.
    wait_frame();
    step();
    step();
    ld = 1'b1;  // coincides with tick
    step();
    ld = 1'b0;
    $display("reload DEC=%h on tick", DEC);
    total++;
    if (an1 !== 4'b1110 || seg1 !== 7'h6F) begin
      bad++;
      $display("FAIL reload_last_old: an=%b seg=%h, required an=1110 seg=6F", an1, seg1);
    end
    for (int j = 1; j <= 12; j++) begin
      step();
      total++;
      if (an1 !== 4'b1111 || seg1 !== 7'h00 || frame1 !== 1'b0) begin
        bad++;
        $display("FAIL reload_blank j=%0d: an=%b seg=%h frame=%b, required an=1111 seg=00 frame=0", j, an1, seg1, frame1);
      end
      if (j == 1) begin
        total++;
        if (an0 !== 4'b1101 || seg0 !== 7'h3F) begin
          bad++;
          $display("FAIL reload_d1_all: an=%b seg=%h, required an=1101 seg=3F", an0, seg0);
        end
      end
    end
    step();
    total++;
    if (an1 !== 4'b1110 || seg1 !== 7'h06 || frame1 !== 1'b1) begin
      bad++;
      $display("FAIL reload_d0: an=%b seg=%h frame=%b, required an=1110 seg=06 frame=1", an1, seg1, frame1);
    end
    $display("test_hold_reload complete");
  endtask

  task automatic test_reset_mid_scan();
    load(16'h4321);
    wait_frame();
    for (int i = 0; i < 8; i++) step();
    total++;
    if (an1 !== 4'b1011 || seg1 !== 7'h4F) begin
      bad++;
      $display("FAIL mid_before: an=%b seg=%h, required an=1011 seg=4F", an1, seg1);
    end
    rst = 1'b1;
    step();
    total++;
    if (an1 !== 4'b1111 || seg1 !== 7'h00 || frame1 !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: an=%b seg=%h frame=%b, required an=1111 seg=00 frame=0", an1, seg1, frame1);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (an1 !== 4'b1110 || seg1 !== 7'h3F || frame1 !== 1'b0) begin
        bad++;
        $display("FAIL mid_restart i=%0d: an=%b seg=%h frame=%b, required an=1110 seg=3F frame=0", i, an1, seg1, frame1);
      end
    end
    step();
    total++;
    if (an1 !== 4'b1111 || seg1 !== 7'h00) begin
      bad++;
      $display("FAIL mid_d1_lzb: an=%b seg=%h, required an=1111 seg=00", an1, seg1);
    end
    total++;
    if (an0 !== 4'b1101 || seg0 !== 7'h3F) begin
      bad++;
      $display("FAIL mid_d1_all: an=%b seg=%h, required an=1101 seg=3F", an0, seg0);
    end
    $display("test_reset_mid_scan complete");
  endtask

  initial begin
    rst = 1'b1;
    ld  = 1'b0;
    DEC = 16'h0000;
    test_reset();
    test_full_scan();
    test_blanking();
    test_invalid();
    test_hold_reload();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
